// File: rtl/controlador_de_partida.sv
// Turn sequencer for the naval-battle game: start/end, shot validation, scoring, lives.
// Ports: clock/reset, iniciar/confirmar_btn buttons, shot coords, mapa0..4 target map in;
//   enable/confirmar/colunaTiro/linhaTiro to the attack manager, score/lives/flags/estado out.
// Optional: define TEMPO_LIMITE_EN to add a per-turn timeout counted as a miss.
module controlador_de_partida #(
  parameter int VIDAS        = 3,
  parameter int TEMPO_LIMITE = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirmar_btn,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic       enable,
  output logic       confirmar,
  output logic [2:0] colunaTiro,
  output logic [2:0] linhaTiro,
  output logic [5:0] acertos,
  output logic [1:0] vidas,
  output logic       vitoria,
  output logic       derrota,
  output logic       repetido,
  output logic       erro_coord,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    JOGANDO = 3'd1,
    ATAQUE  = 3'd2,
    AVALIA  = 3'd3,
    VITORIA = 3'd4,
    DERROTA = 3'd5
  } estado_t;

  estado_t     state_q, state_d;
  logic        ini_q, conf_q;
  logic [34:0] mask_q, mask_d;
  logic [5:0]  alvos_q, alvos_d;
  logic [5:0]  acertos_q, acertos_d;
  logic [1:0]  vidas_q, vidas_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  lin_q, lin_d;
  logic        acerto_q, acerto_d;
  logic        rep_q, rep_d;
  logic        err_q, err_d;

  logic        ini_e, conf_e;
  logic        fora, aceito;
  logic [5:0]  in_idx, sh_idx;
  logic [6:0]  mapas [5];

  assign mapas[0] = mapa0;
  assign mapas[1] = mapa1;
  assign mapas[2] = mapa2;
  assign mapas[3] = mapa3;
  assign mapas[4] = mapa4;

  assign ini_e  = iniciar & ~ini_q;
  assign conf_e = confirmar_btn & ~conf_q;

  // Cell index in the fired mask: column-major, 7 rows per column.
  assign in_idx = {3'b000, coordColuna} * 6'd7 + {3'b000, coordLinha};
  assign sh_idx = {3'b000, col_q} * 6'd7 + {3'b000, lin_q};
  assign fora   = (coordColuna > 3'd4) || (coordLinha > 3'd6);
  assign aceito = (state_q == JOGANDO) && conf_e && !fora && !mask_q[in_idx];

  function automatic logic [5:0] pop35(input logic [34:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 35; i++) n = n + {5'b0, v[i]};
    return n;
  endfunction

`ifdef TEMPO_LIMITE_EN
  logic [25:0] timer_q, timer_d;
  logic        expirou;
  assign expirou = (timer_q == 26'(TEMPO_LIMITE - 1));
  // Restarts on every cycle outside JOGANDO, so each entry begins at zero.
  assign timer_d = (state_q == JOGANDO && state_d == JOGANDO) ?
                   timer_q + 26'd1 : 26'd0;
  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  logic expirou;
  logic unused_tempo;
  assign expirou      = 1'b0;
  assign unused_tempo = (TEMPO_LIMITE == 0);
`endif

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    alvos_d   = alvos_q;
    acertos_d = acertos_q;
    vidas_d   = vidas_q;
    col_d     = col_q;
    lin_d     = lin_q;
    acerto_d  = acerto_q;
    rep_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (ini_e) begin
          alvos_d   = pop35({mapa4, mapa3, mapa2, mapa1, mapa0});
          acertos_d = '0;
          mask_d    = '0;
          vidas_d   = 2'(VIDAS);
          acerto_d  = 1'b0;
          state_d   = JOGANDO;
        end
      end
      JOGANDO: begin
        if (alvos_q == 6'd0) begin
          state_d = VITORIA;
        end else begin
          if (conf_e) begin
            if (fora) begin
              err_d = 1'b1;
            end else if (mask_q[in_idx]) begin
              rep_d = 1'b1;
            end else begin
              col_d   = coordColuna;
              lin_d   = coordLinha;
              state_d = ATAQUE;
            end
          end
          // Timeout goes straight to scoring as a miss, bypassing ATAQUE.
          if (!aceito && expirou) begin
            acerto_d = 1'b0;
            state_d  = AVALIA;
          end
        end
      end
      ATAQUE: begin
        mask_d[sh_idx] = 1'b1;
        acerto_d       = mapas[col_q][lin_q];
        state_d        = AVALIA;
      end
      AVALIA: begin
        if (acerto_q) begin
          acertos_d = acertos_q + 6'd1;
          state_d   = (acertos_q + 6'd1 == alvos_q) ? VITORIA : JOGANDO;
        end else begin
          vidas_d = vidas_q - 2'd1;
          state_d = (vidas_q == 2'd1) ? DERROTA : JOGANDO;
        end
      end
      VITORIA, DERROTA: begin
        if (ini_e) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= OCIOSO;
      ini_q     <= 1'b0;
      conf_q    <= 1'b0;
      mask_q    <= '0;
      alvos_q   <= '0;
      acertos_q <= '0;
      vidas_q   <= 2'(VIDAS);
      col_q     <= '0;
      lin_q     <= '0;
      acerto_q  <= 1'b0;
      rep_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ini_q     <= iniciar;
      conf_q    <= confirmar_btn;
      mask_q    <= mask_d;
      alvos_q   <= alvos_d;
      acertos_q <= acertos_d;
      vidas_q   <= vidas_d;
      col_q     <= col_d;
      lin_q     <= lin_d;
      acerto_q  <= acerto_d;
      rep_q     <= rep_d;
      err_q     <= err_d;
    end
  end

  assign enable     = (state_q != OCIOSO);
  assign confirmar  = (state_q == ATAQUE);
  assign colunaTiro = col_q;
  assign linhaTiro  = lin_q;
  assign acertos    = acertos_q;
  assign vidas      = vidas_q;
  assign vitoria    = (state_q == VITORIA);
  assign derrota    = (state_q == DERROTA);
  assign repetido   = rep_q;
  assign erro_coord = err_q;
  assign estado     = state_q;

endmodule

// File: tb/tb_controlador_de_partida.sv
// Directed self-checking bench for controlador_de_partida.
// Covers reset, win, loss, repeats, range errors, edges, zero targets, timer.
module tb_controlador_de_partida;

  logic       clk = 1'b0;
  logic       reset, iniciar, confirmar_btn;
  logic [2:0] coordColuna, coordLinha;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic       enable, confirmar, vitoria, derrota, repetido, erro_coord;
  logic [2:0] colunaTiro, linhaTiro, estado;
  logic [5:0] acertos;
  logic [1:0] vidas;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controlador_de_partida #(.VIDAS(3), .TEMPO_LIMITE(8)) dut (
    .clock(clk), .reset(reset), .iniciar(iniciar),
    .confirmar_btn(confirmar_btn),
    .coordColuna(coordColuna), .coordLinha(coordLinha),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2),
    .mapa3(mapa3), .mapa4(mapa4),
    .enable(enable), .confirmar(confirmar),
    .colunaTiro(colunaTiro), .linhaTiro(linhaTiro),
    .acertos(acertos), .vidas(vidas),
    .vitoria(vitoria), .derrota(derrota),
    .repetido(repetido), .erro_coord(erro_coord),
    .estado(estado)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  task automatic press(input logic [2:0] c, input logic [2:0] l);
    coordColuna   = c;
    coordLinha    = l;
    confirmar_btn = 1'b1;
    tick();
    confirmar_btn = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (estado !== 3'd0) begin
      errors++; $display("FAIL rst_estado got %0d exp 0", estado);
    end
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL rst_enable got %b exp 0", enable);
    end
    checks++;
    if (vidas !== 2'd3) begin
      errors++; $display("FAIL rst_vidas got %0d exp 3", vidas);
    end
    checks++;
    if (acertos !== 6'd0) begin
      errors++; $display("FAIL rst_acertos got %0d exp 0", acertos);
    end
    checks++;
    if ({confirmar, repetido, erro_coord, vitoria, derrota} !== 5'b0) begin
      errors++;
      $display("FAIL rst_pulses got %b exp 00000",
               {confirmar, repetido, erro_coord, vitoria, derrota});
    end
    checks++;
    if ({colunaTiro, linhaTiro} !== 6'd0) begin
      errors++; $display("FAIL rst_tiro got %0d/%0d exp 0/0", colunaTiro, linhaTiro);
    end
  endtask

  task automatic test_win;
    mapa0 = 7'b0000011; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    start();
    checks++;
    if (estado !== 3'd1 || enable !== 1'b1) begin
      errors++; $display("FAIL win_start estado %0d en %b exp 1 1", estado, enable);
    end
    press(3'd0, 3'd0);
    checks++;
    if (confirmar !== 1'b1) begin
      errors++; $display("FAIL win_conf1 got %b exp 1", confirmar);
    end
    tick();
    checks++;
    if (confirmar !== 1'b0 || estado !== 3'd3) begin
      errors++; $display("FAIL win_aval conf %b estado %0d exp 0 3", confirmar, estado);
    end
    tick();
    checks++;
    if (acertos !== 6'd1 || estado !== 3'd1) begin
      errors++; $display("FAIL win_hit1 acertos %0d estado %0d exp 1 1", acertos, estado);
    end
    press(3'd0, 3'd1);
    checks++;
    if (confirmar !== 1'b1 || linhaTiro !== 3'd1 || colunaTiro !== 3'd0) begin
      errors++;
      $display("FAIL win_conf2 conf %b lin %0d col %0d exp 1 1 0",
               confirmar, linhaTiro, colunaTiro);
    end
    tick();
    tick();
    checks++;
    if (acertos !== 6'd2 || vitoria !== 1'b1 || estado !== 3'd4 || enable !== 1'b1) begin
      errors++;
      $display("FAIL win_end acertos %0d vit %b estado %0d en %b exp 2 1 4 1",
               acertos, vitoria, estado, enable);
    end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (estado !== 3'd0 || enable !== 1'b0 || vitoria !== 1'b0) begin
      errors++;
      $display("FAIL win_back estado %0d en %b vit %b exp 0 0 0", estado, enable, vitoria);
    end
  endtask

  task automatic test_loss;
    mapa0 = 7'b0000011; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    start();
    for (int i = 1; i <= 3; i++) begin
      press(3'(i), 3'd0);
      checks++;
      if (confirmar !== 1'b1) begin
        errors++; $display("FAIL loss_conf%0d got %b exp 1", i, confirmar);
      end
      tick();
      tick();
      checks++;
      if (vidas !== 2'(3 - i)) begin
        errors++; $display("FAIL loss_vidas%0d got %0d exp %0d", i, vidas, 3 - i);
      end
    end
    checks++;
    if (derrota !== 1'b1 || estado !== 3'd5 || enable !== 1'b1 || acertos !== 6'd0) begin
      errors++;
      $display("FAIL loss_end der %b estado %0d en %b ac %0d exp 1 5 1 0",
               derrota, estado, enable, acertos);
    end
  endtask

  task automatic test_held;
    int n;
    mapa0 = 7'b0000011; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    start();
    n = 0;
    coordColuna   = 3'd1;
    coordLinha    = 3'd1;
    confirmar_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (confirmar === 1'b1) n++;
    end
    confirmar_btn = 1'b0;
    checks++;
    if (n != 1 || vidas !== 2'd2) begin
      errors++; $display("FAIL held pulses %0d vidas %0d exp 1 2", n, vidas);
    end
  endtask

  task automatic test_repeat;
    mapa0 = 7'b0000011; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    start();
    press(3'd0, 3'd0);
    tick();
    tick();
    press(3'd0, 3'd0);
    checks++;
    if (repetido !== 1'b1 || confirmar !== 1'b0 || estado !== 3'd1) begin
      errors++;
      $display("FAIL rep_pulse rep %b conf %b estado %0d exp 1 0 1",
               repetido, confirmar, estado);
    end
    tick();
    checks++;
    if (repetido !== 1'b0 || acertos !== 6'd1 || vidas !== 2'd3) begin
      errors++;
      $display("FAIL rep_after rep %b ac %0d vidas %0d exp 0 1 3",
               repetido, acertos, vidas);
    end
  endtask

  task automatic test_coord;
    mapa0 = 7'b0000011; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    start();
    press(3'd5, 3'd0);
    checks++;
    if (erro_coord !== 1'b1 || estado !== 3'd1 || confirmar !== 1'b0) begin
      errors++;
      $display("FAIL coord_col err %b estado %0d conf %b exp 1 1 0",
               erro_coord, estado, confirmar);
    end
    tick();
    checks++;
    if (erro_coord !== 1'b0) begin
      errors++; $display("FAIL coord_clear got %b exp 0", erro_coord);
    end
    press(3'd0, 3'd7);
    checks++;
    if (erro_coord !== 1'b1 || estado !== 3'd1) begin
      errors++; $display("FAIL coord_lin err %b estado %0d exp 1 1", erro_coord, estado);
    end
    tick();
  endtask

  task automatic test_edges;
    mapa0 = 7'b0000011; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    checks++;
    if (estado !== 3'd1) begin
      errors++; $display("FAIL ini_ignored estado %0d exp 1", estado);
    end
    iniciar = 1'b1;
    press(3'd2, 3'd2);
    iniciar = 1'b0;
    checks++;
    if (confirmar !== 1'b1 || estado !== 3'd2) begin
      errors++; $display("FAIL both_edges conf %b estado %0d exp 1 2", confirmar, estado);
    end
    coordColuna   = 3'd0;
    coordLinha    = 3'd1;
    confirmar_btn = 1'b1;
    tick();
    tick();
    tick();
    confirmar_btn = 1'b0;
    checks++;
    if (estado !== 3'd1 || confirmar !== 1'b0 || vidas !== 2'd2) begin
      errors++;
      $display("FAIL dropped estado %0d conf %b vidas %0d exp 1 0 2",
               estado, confirmar, vidas);
    end
  endtask

  task automatic test_zero;
    mapa0 = '0; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (estado !== 3'd1) begin
      errors++; $display("FAIL zero_jog estado %0d exp 1", estado);
    end
    tick();
    checks++;
    if (estado !== 3'd4 || vitoria !== 1'b1) begin
      errors++; $display("FAIL zero_win estado %0d vit %b exp 4 1", estado, vitoria);
    end
  endtask

  task automatic test_reset_mid;
    mapa0 = 7'b0000011; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    start();
    press(3'd1, 3'd1);
    checks++;
    if (estado !== 3'd2 || confirmar !== 1'b1) begin
      errors++; $display("FAIL mid_atq estado %0d conf %b exp 2 1", estado, confirmar);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (estado !== 3'd0 || confirmar !== 1'b0 || enable !== 1'b0 || vidas !== 2'd3) begin
      errors++;
      $display("FAIL mid_rst estado %0d conf %b en %b vidas %0d exp 0 0 0 3",
               estado, confirmar, enable, vidas);
    end
  endtask

  task automatic test_timer;
    int n;
    mapa0 = 7'b0000011; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    do_reset();
    start();
    n = 0;
`ifdef TEMPO_LIMITE_EN
    for (int i = 0; i < 30; i++) begin
      if (vidas === 2'd2) break;
      tick();
      if (confirmar === 1'b1) n++;
    end
    checks++;
    if (vidas !== 2'd2 || n != 0 || estado !== 3'd1) begin
      errors++;
      $display("FAIL timer vidas %0d conf %0d estado %0d exp 2 0 1", vidas, n, estado);
    end
`else
    for (int i = 0; i < 30; i++) begin
      tick();
      if (confirmar === 1'b1) n++;
    end
    checks++;
    if (vidas !== 2'd3 || n != 0 || estado !== 3'd1) begin
      errors++;
      $display("FAIL no_timer vidas %0d conf %0d estado %0d exp 3 0 1", vidas, n, estado);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; confirmar_btn = 1'b0;
    coordColuna = '0; coordLinha = '0;
    mapa0 = '0; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    test_reset();
    test_win();
    test_loss();
    test_held();
    test_repeat();
    test_coord();
    test_edges();
    test_zero();
    test_reset_mid();
    test_timer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
